// File: rtl/csr_pkg.sv
// Shared CSR definitions: op encodings, well-known CSR addresses, arbiter state and owner types.
// No logic beyond a tiny helper deciding whether an op needs a write phase.
// Imported by the arbiter, its pick sub-module and the bench.
package csr_pkg;

  localparam logic [1:0] CSR_OP_READ  = 2'b00;
  localparam logic [1:0] CSR_OP_WRITE = 2'b01;
  localparam logic [1:0] CSR_OP_SET   = 2'b10;
  localparam logic [1:0] CSR_OP_CLR   = 2'b11;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } csr_state_t;

  typedef enum logic [1:0] {
    OWN_T = 2'd0,
    OWN_P = 2'd1,
    OWN_D = 2'd2
  } csr_owner_t;

  // A plain write always writes; set/clear with an all-zero mask leaves the CSR untouched
  // (CSRRS/CSRRC with rs1 = x0 must not cause write side effects).
  function automatic logic csr_needs_write(input logic [1:0] op, input logic mask_nz);
    return (op == CSR_OP_WRITE) || (op[1] && mask_nz);
  endfunction

endpackage

// File: rtl/csr_rr_pick.sv
// Requester pick: trap engine has absolute priority, pipe/debug share by a round-robin pointer.
// Purely combinational; the caller only consults it in IDLE.
// ptr_d = 0 favours the pipe, 1 favours debug.
module csr_rr_pick
  import csr_pkg::*;
(
  input  logic       t_req,
  input  logic       p_req,
  input  logic       d_req,
  input  logic       ptr_d,
  output logic       vld,
  output csr_owner_t owner
);

  // Fixed priority for t, pointer tie-break between p and d
  always_comb begin
    vld   = t_req | p_req | d_req;
    owner = OWN_T;
    if (t_req)              owner = OWN_T;
    else if (p_req && d_req) owner = ptr_d ? OWN_D : OWN_P;
    else if (p_req)         owner = OWN_P;
    else if (d_req)         owner = OWN_D;
  end

endmodule

// File: rtl/csr_port_arbiter.sv
// Three-way arbiter owning the CSRRegs port: each access is READ, optional WRITE, then DONE.
// Latency: done in cycle 3 after the request edge with a write, cycle 2 without.
// Requesters hold req until done; a locked trap engine chains ops with no IDLE gap.
module csr_port_arbiter
  import csr_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              t_req,
  input  logic [ADDR_W-1:0] t_addr,
  input  logic [1:0]        t_op,
  input  logic [DATA_W-1:0] t_wdata,
  input  logic              t_lock,
  input  logic              p_req,
  input  logic [ADDR_W-1:0] p_addr,
  input  logic [1:0]        p_op,
  input  logic [DATA_W-1:0] p_wdata,
  input  logic              p_kill,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [1:0]        d_op,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              t_gnt,
  output logic              t_done,
  output logic [DATA_W-1:0] t_rdata,
  output logic              p_gnt,
  output logic              p_done,
  output logic [DATA_W-1:0] p_rdata,
  output logic              d_gnt,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              csr_w,
  output logic [ADDR_W-1:0] csr_raddr,
  output logic [ADDR_W-1:0] csr_waddr,
  output logic [DATA_W-1:0] csr_wdata,
  input  logic [DATA_W-1:0] csr_rdata
);

  csr_state_t        state, state_nxt;
  csr_owner_t        owner_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        op_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] old_q;
  logic              ptr_d;

  logic              pick_vld;
  csr_owner_t        pick_owner;
  logic              chain;
  logic              kill;
  logic              write_req;
  logic              load;
  csr_owner_t        sel_owner;
  logic [ADDR_W-1:0] sel_addr;
  logic [1:0]        sel_op;
  logic [DATA_W-1:0] sel_wdata;
  logic [DATA_W-1:0] new_val;

  csr_rr_pick u_pick (
    .t_req (t_req),
    .p_req (p_req),
    .d_req (d_req),
    .ptr_d (ptr_d),
    .vld   (pick_vld),
    .owner (pick_owner)
  );

  // Locked trap engine re-enters READ straight from DONE; a kill only bites before the write
  assign chain     = (state == ST_DONE) && (owner_q == OWN_T) && t_lock && t_req;
  assign kill      = (state == ST_READ) && (owner_q == OWN_P) && p_kill;
  assign write_req = csr_needs_write(op_q, |wdata_q);
  assign load      = ((state == ST_IDLE) && pick_vld) || chain;
  assign sel_owner = chain ? OWN_T : pick_owner;

  // Fields of the requester about to own the port
  always_comb begin
    sel_addr  = t_addr;
    sel_op    = t_op;
    sel_wdata = t_wdata;
    case (sel_owner)
      OWN_P: begin
        sel_addr  = p_addr;
        sel_op    = p_op;
        sel_wdata = p_wdata;
      end
      OWN_D: begin
        sel_addr  = d_addr;
        sel_op    = d_op;
        sel_wdata = d_wdata;
      end
      default: ;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (pick_vld) state_nxt = ST_READ;
      ST_READ: begin
        if (kill)           state_nxt = ST_IDLE;
        else if (write_req) state_nxt = ST_WRITE;
        else                state_nxt = ST_DONE;
      end
      ST_WRITE: state_nxt = ST_DONE;
      ST_DONE:  state_nxt = chain ? ST_READ : ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Access context: owner and fields latched at grant, old value captured in READ, RR pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q <= OWN_T;
      addr_q  <= '0;
      op_q    <= CSR_OP_READ;
      wdata_q <= '0;
      old_q   <= '0;
      ptr_d   <= 1'b0;
    end else begin
      if (load) begin
        owner_q <= sel_owner;
        addr_q  <= sel_addr;
        op_q    <= sel_op;
        wdata_q <= sel_wdata;
      end
      if (state == ST_READ) old_q <= csr_rdata;
      if (kill) begin
        ptr_d <= 1'b1;
      end else if ((state == ST_DONE) && (owner_q != OWN_T)) begin
        ptr_d <= (owner_q == OWN_P);
      end
    end
  end

  // Read-modify-write value, all in DATA_W bits
  always_comb begin
    case (op_q)
      CSR_OP_WRITE: new_val = wdata_q;
      CSR_OP_SET:   new_val = old_q | wdata_q;
      CSR_OP_CLR:   new_val = old_q & ~wdata_q;
      default:      new_val = old_q;
    endcase
  end

  // Outputs decoded from the state register and latched context only
  always_comb begin
    t_gnt     = 1'b0;
    p_gnt     = 1'b0;
    d_gnt     = 1'b0;
    t_done    = 1'b0;
    p_done    = 1'b0;
    d_done    = 1'b0;
    csr_w     = 1'b0;
    csr_wdata = '0;
    if ((state == ST_READ) || (state == ST_WRITE)) begin
      t_gnt = (owner_q == OWN_T);
      p_gnt = (owner_q == OWN_P);
      d_gnt = (owner_q == OWN_D);
    end
    if (state == ST_DONE) begin
      t_done = (owner_q == OWN_T);
      p_done = (owner_q == OWN_P);
      d_done = (owner_q == OWN_D);
    end
    if (state == ST_WRITE) begin
      csr_w     = 1'b1;
      csr_wdata = new_val;
    end
  end

  assign csr_raddr = addr_q;
  assign csr_waddr = addr_q;
  assign t_rdata   = old_q;
  assign p_rdata   = old_q;
  assign d_rdata   = old_q;

endmodule

// File: tb/tb_csr_port_arbiter.sv
// Bench for csr_port_arbiter with a behavioural CSR register file on its port.
// Vector table for single accesses, hand sequences for lock chain, round-robin, kill and reset.
// Expected rdata/owner queued on issue and popped when a done pulse appears.
module tb_csr_port_arbiter;
  import csr_pkg::*;

  localparam int AW = 12;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          t_req, p_req, d_req, t_lock, p_kill;
  logic [AW-1:0] t_addr, p_addr, d_addr;
  logic [1:0]    t_op, p_op, d_op;
  logic [DW-1:0] t_wdata, p_wdata, d_wdata;
  logic          t_gnt, p_gnt, d_gnt, t_done, p_done, d_done;
  logic [DW-1:0] t_rdata, p_rdata, d_rdata;
  logic          csr_w;
  logic [AW-1:0] csr_raddr, csr_waddr;
  logic [DW-1:0] csr_wdata, csr_rdata;

  logic [DW-1:0] regs [0:4095];
  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [DW-1:0] pl_dat = '0;
  int            wr_cnt = 0;
  int            done_t = 0, done_p = 0, done_d = 0;

  int n_checks = 0;
  int n_pass = 0;

  typedef struct {
    int          who;
    logic [31:0] rdata;
  } sb_t;
  sb_t sbq[$];

  typedef struct {
    int          who;
    logic [11:0] addr;
    logic [1:0]  op;
    logic [31:0] wdata;
    logic [31:0] init;
    bit          wr;
    logic [31:0] fin;
    int          lat;
  } vec_t;
  vec_t vecs[8];

  always #5 clk = ~clk;

  csr_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .t_req(t_req), .t_addr(t_addr), .t_op(t_op), .t_wdata(t_wdata), .t_lock(t_lock),
    .p_req(p_req), .p_addr(p_addr), .p_op(p_op), .p_wdata(p_wdata), .p_kill(p_kill),
    .d_req(d_req), .d_addr(d_addr), .d_op(d_op), .d_wdata(d_wdata),
    .t_gnt(t_gnt), .t_done(t_done), .t_rdata(t_rdata),
    .p_gnt(p_gnt), .p_done(p_done), .p_rdata(p_rdata),
    .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata),
    .csr_w(csr_w), .csr_raddr(csr_raddr), .csr_waddr(csr_waddr),
    .csr_wdata(csr_wdata), .csr_rdata(csr_rdata)
  );

  // CSR register file model: combinational read, write on the clock edge
  assign csr_rdata = regs[csr_raddr];
  always @(posedge clk) begin
    if (pl_en) regs[pl_addr] <= pl_dat;
    else if (csr_w) regs[csr_waddr] <= csr_wdata;
  end

  // Count committed writes
  always @(posedge clk) if (csr_w) wr_cnt <= wr_cnt + 1;

  // Count done pulses per requester
  always @(negedge clk) begin
    if (t_done) done_t <= done_t + 1;
    if (p_done) done_p <= done_p + 1;
    if (d_done) done_d <= done_d + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
  endtask

  task automatic set_req(input int who, input logic r, input logic [11:0] a,
                         input logic [1:0] o, input logic [31:0] w);
    case (who)
      0: begin t_req = r; t_addr = a; t_op = o; t_wdata = w; end
      1: begin p_req = r; p_addr = a; p_op = o; p_wdata = w; end
      default: begin d_req = r; d_addr = a; d_op = o; d_wdata = w; end
    endcase
  endtask

  task automatic preload(input logic [11:0] a, input logic [31:0] v);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_dat = v;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Step negedges until any done pulse; k counts cycles from the call point
  task automatic run_until_done(output int who, output int cyc, output int wcyc,
                                output logic [31:0] wdat, output logic [31:0] rd);
    who = -1; cyc = 0; wcyc = 0; wdat = '0; rd = '0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (csr_w) begin wcyc = k; wdat = csr_wdata; end
      if (t_done | p_done | d_done) begin
        who = t_done ? 0 : (p_done ? 1 : 2);
        rd  = t_done ? t_rdata : (p_done ? p_rdata : d_rdata);
        cyc = k;
        break;
      end
    end
    chk("done_seen", (who >= 0), 1);
  endtask

  task automatic sb_check(input int who, input logic [31:0] rd);
    sb_t e;
    chk("sb_nonempty", (sbq.size() > 0), 1);
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("sb_owner", who, e.who);
      chk("sb_rdata", rd, e.rdata);
    end
  endtask

  initial begin
    int who, cyc, wcyc, w0, d0, pg_first, ndone;
    int tdc[3];
    logic [31:0] wdat, rd;

    t_req = 0; p_req = 0; d_req = 0; t_lock = 0; p_kill = 0;
    t_addr = '0; p_addr = '0; d_addr = '0; t_op = '0; p_op = '0; d_op = '0;
    t_wdata = '0; p_wdata = '0; d_wdata = '0;

    vecs[0] = '{1, CSR_MTVEC,   CSR_OP_READ,  32'h0000_FFFF, 32'h0000_1000, 1'b0, 32'h0000_1000, 2};
    vecs[1] = '{2, CSR_MSTATUS, CSR_OP_SET,   32'h0000_0008, 32'h0000_0080, 1'b1, 32'h0000_0088, 3};
    vecs[2] = '{2, CSR_MSTATUS, CSR_OP_SET,   32'h0000_0000, 32'h0000_0080, 1'b0, 32'h0000_0080, 2};
    vecs[3] = '{0, CSR_MEPC,    CSR_OP_WRITE, 32'h0000_0024, 32'h0000_0005, 1'b1, 32'h0000_0024, 3};
    vecs[4] = '{1, CSR_MSTATUS, CSR_OP_CLR,   32'h0000_000F, 32'h0000_00FF, 1'b1, 32'h0000_00F0, 3};
    vecs[5] = '{1, CSR_MSTATUS, CSR_OP_CLR,   32'h0000_0000, 32'h0000_00FF, 1'b0, 32'h0000_00FF, 2};
    vecs[6] = '{2, CSR_MCAUSE,  CSR_OP_WRITE, 32'h0000_0000, 32'h0000_DEAD, 1'b1, 32'h0000_0000, 3};
    vecs[7] = '{0, CSR_MSTATUS, CSR_OP_SET,   32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 32'hFFFF_FFFF, 3};

    // Reset values
    @(negedge clk);
    chk("rst_gnt",   {t_gnt, p_gnt, d_gnt}, 0);
    chk("rst_done",  {t_done, p_done, d_done}, 0);
    chk("rst_csr_w", csr_w, 0);
    chk("rst_addr",  {csr_raddr, csr_waddr}, 0);
    chk("rst_wdata", csr_wdata, 0);
    chk("rst_rdata", t_rdata | p_rdata | d_rdata, 0);
    chk("rst_state", dut.state, ST_IDLE);
    @(negedge clk);
    rst = 1'b0;

    // Single accesses from the vector table
    for (int i = 0; i < 8; i++) begin
      preload(vecs[i].addr, vecs[i].init);
      sbq.push_back('{vecs[i].who, vecs[i].init});
      w0 = wr_cnt;
      set_req(vecs[i].who, 1'b1, vecs[i].addr, vecs[i].op, vecs[i].wdata);
      run_until_done(who, cyc, wcyc, wdat, rd);
      set_req(vecs[i].who, 1'b0, '0, '0, '0);
      sb_check(who, rd);
      chk($sformatf("v%0d_latency", i), cyc, vecs[i].lat);
      if (vecs[i].wr) begin
        chk($sformatf("v%0d_wcycle", i), wcyc, 2);
        chk($sformatf("v%0d_wdata", i), wdat, vecs[i].fin);
      end
      @(negedge clk);
      chk($sformatf("v%0d_idle_gnt", i), {t_gnt, p_gnt, d_gnt}, 0);
      chk($sformatf("v%0d_writes", i), wr_cnt - w0, vecs[i].wr ? 1 : 0);
      chk($sformatf("v%0d_csr", i), regs[vecs[i].addr], vecs[i].fin);
    end

    // Locked trap chain of three writes while the pipe waits
    reset_dut();
    preload(CSR_MSTATUS, 32'h0);
    preload(CSR_MEPC, 32'h5);
    preload(CSR_MCAUSE, 32'h0);
    preload(CSR_MTVEC, 32'h1000);
    sbq.push_back('{0, 32'h0});
    sbq.push_back('{0, 32'h5});
    sbq.push_back('{0, 32'h0});
    sbq.push_back('{1, 32'h1000});
    w0 = wr_cnt;
    set_req(0, 1'b1, CSR_MSTATUS, CSR_OP_WRITE, 32'h1888);
    t_lock = 1'b1;
    set_req(1, 1'b1, CSR_MTVEC, CSR_OP_READ, 32'h0);
    pg_first = 0; ndone = 0; cyc = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (p_gnt && pg_first == 0) pg_first = k;
      if (t_done) begin
        if (ndone < 3) tdc[ndone] = k;
        ndone++;
        sb_check(0, t_rdata);
        if (ndone == 1) set_req(0, 1'b1, CSR_MEPC, CSR_OP_WRITE, 32'h24);
        else if (ndone == 2) set_req(0, 1'b1, CSR_MCAUSE, CSR_OP_WRITE, 32'd11);
        else begin t_req = 1'b0; t_lock = 1'b0; end
      end
      if (p_done) begin
        cyc = k;
        sb_check(1, p_rdata);
        p_req = 1'b0;
        break;
      end
    end
    chk("lock_done1", tdc[0], 3);
    chk("lock_done2", tdc[1], 6);
    chk("lock_done3", tdc[2], 9);
    chk("lock_pgnt_first", pg_first, 11);
    chk("lock_pdone", cyc, 12);
    chk("lock_writes", wr_cnt - w0, 3);
    chk("lock_mstatus", regs[CSR_MSTATUS], 32'h1888);
    chk("lock_mepc", regs[CSR_MEPC], 32'h24);
    chk("lock_mcause", regs[CSR_MCAUSE], 32'd11);

    // Continuous p/d requests alternate; a trap request wins the next IDLE
    reset_dut();
    sbq.push_back('{1, 32'h1000});
    sbq.push_back('{2, 32'h24});
    sbq.push_back('{1, 32'h1000});
    sbq.push_back('{2, 32'h24});
    sbq.push_back('{0, 32'd11});
    sbq.push_back('{1, 32'h1000});
    set_req(1, 1'b1, CSR_MTVEC, CSR_OP_READ, 32'h0);
    set_req(2, 1'b1, CSR_MEPC, CSR_OP_READ, 32'h0);
    for (int i = 0; i < 6; i++) begin
      run_until_done(who, cyc, wcyc, wdat, rd);
      sb_check(who, rd);
      if (i == 3) set_req(0, 1'b1, CSR_MCAUSE, CSR_OP_READ, 32'h0);
      if (who == 0) t_req = 1'b0;
      if (i == 5) begin p_req = 1'b0; d_req = 1'b0; end
    end
    @(negedge clk);

    // Pipe kill in READ: no write, no p_done, debug granted next
    reset_dut();
    preload(CSR_MSTATUS, 32'h55);
    sbq.push_back('{2, 32'h1000});
    w0 = wr_cnt; d0 = done_p;
    set_req(1, 1'b1, CSR_MSTATUS, CSR_OP_WRITE, 32'h1234);
    set_req(2, 1'b1, CSR_MTVEC, CSR_OP_READ, 32'h0);
    @(negedge clk);
    chk("kill_pgnt", p_gnt, 1);
    p_kill = 1'b1;
    @(negedge clk);
    chk("kill_idle_gnt", {t_gnt, p_gnt, d_gnt}, 0);
    p_kill = 1'b0;
    @(negedge clk);
    chk("kill_next_gnt", {p_gnt, d_gnt}, 2'b01);
    p_req = 1'b0;
    run_until_done(who, cyc, wcyc, wdat, rd);
    d_req = 1'b0;
    sb_check(who, rd);
    chk("kill_dlat", cyc, 1);
    @(negedge clk);
    chk("kill_writes", wr_cnt - w0, 0);
    chk("kill_csr", regs[CSR_MSTATUS], 32'h55);
    chk("kill_no_pdone", done_p - d0, 0);

    // Reset asserted during WRITE suppresses the write
    preload(CSR_MEPC, 32'h77);
    w0 = wr_cnt; d0 = done_d;
    set_req(2, 1'b1, CSR_MEPC, CSR_OP_WRITE, 32'hABCD);
    @(negedge clk);
    chk("rstw_dgnt", d_gnt, 1);
    @(negedge clk);
    chk("rstw_csr_w_before", csr_w, 1);
    #1 rst = 1'b1;
    #1;
    chk("rstw_csr_w_after", csr_w, 0);
    chk("rstw_gnt", {t_gnt, p_gnt, d_gnt}, 0);
    set_req(2, 1'b0, '0, '0, '0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rstw_state", dut.state, ST_IDLE);
    chk("rstw_csr", regs[CSR_MEPC], 32'h77);
    chk("rstw_writes", wr_cnt - w0, 0);
    chk("rstw_no_ddone", done_d - d0, 0);

    chk("sb_drained", sbq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
